// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select codes, shadow entry, match helper.
// Purely declarative; no timing or flow-control behaviour of its own.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Shadow rd is stored at a fixed width so the struct stays unparameterised; REG_AW must not exceed it.
  localparam int RD_W = 8;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  function automatic logic dst_match(input logic [RD_W-1:0] src, input shadow_entry_t ent);
    return ent.valid & ent.regwrite & (src != '0) & (src == ent.rd);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_shadow_stage.sv
// One shadow pipeline entry: reset clears, hold freezes, bubble inserts an empty entry, otherwise loads d.
// One cycle from d to q; hold has priority over bubble.
module hazard_shadow_stage
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          bubble,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SHADOW_BUBBLE;
    end else if (!hold) begin
      q <= bubble ? SHADOW_BUBBLE : d;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline; outputs combinational from shadow E/M/W + D/E inputs.
// Optional perf counters under HAZARD_PERF_EN; ext_stall_i freezes the shadow and suppresses the E bubble.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NRS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AW-1:0]     rd_d_i,
  input  logic                  regwrite_d_i,
  input  logic                  memread_d_i,
  input  logic [NRS*REG_AW-1:0] rs_d_i,
  input  logic [NRS-1:0]        rs_use_d_i,
  input  logic                  branch_d_i,
  input  logic [NRS*REG_AW-1:0] rs_e_i,
  input  logic                  flush_e_i,
  input  logic                  ext_stall_i,
  output logic [NRS*2-1:0]      fwd_e_o,
  output logic [NRS-1:0]        fwd_d_o,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  flush_e_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           bubble_cnt_o
`endif
);

  shadow_entry_t d_ent;
  shadow_entry_t e_q;
  shadow_entry_t m_q;
  shadow_entry_t w_q;
  logic [NRS-1:0] haz_port;
  logic           hazard;
  logic           e_bubble;

  always_comb begin
    d_ent          = SHADOW_BUBBLE;
    d_ent.valid    = 1'b1;
    d_ent.rd       = RD_W'(rd_d_i);
    d_ent.regwrite = regwrite_d_i;
    d_ent.memread  = memread_d_i;
  end

  assign e_bubble = hazard | flush_e_i;

  hazard_shadow_stage u_shadow_e (
    .clk(clk), .rst(rst), .hold(ext_stall_i), .bubble(e_bubble), .d(d_ent), .q(e_q)
  );
  hazard_shadow_stage u_shadow_m (
    .clk(clk), .rst(rst), .hold(ext_stall_i), .bubble(1'b0), .d(e_q), .q(m_q)
  );
  hazard_shadow_stage u_shadow_w (
    .clk(clk), .rst(rst), .hold(ext_stall_i), .bubble(1'b0), .d(m_q), .q(w_q)
  );

  for (genvar k = 0; k < NRS; k++) begin : g_port
    logic [RD_W-1:0] rs_d;
    logic [RD_W-1:0] rs_e;
    logic            e_from_m;
    logic            e_from_w;
    logic            d_match_e;
    logic            d_match_m;

    assign rs_d = RD_W'(rs_d_i[k*REG_AW +: REG_AW]);
    assign rs_e = RD_W'(rs_e_i[k*REG_AW +: REG_AW]);

    // A load in M has no data yet, so it can never be the M-stage forward source.
    assign e_from_m  = dst_match(rs_e, m_q) & ~m_q.memread;
    assign e_from_w  = dst_match(rs_e, w_q);
    assign d_match_e = dst_match(rs_d, e_q);
    assign d_match_m = dst_match(rs_d, m_q);

    assign fwd_e_o[2*k +: 2] = e_from_m ? FWD_M : (e_from_w ? FWD_W : FWD_RF);
    assign fwd_d_o[k]        = d_match_m & ~m_q.memread;

    assign haz_port[k] = rs_use_d_i[k] &
                         ((e_q.memread & d_match_e) |
                          (branch_d_i & d_match_e) |
                          (branch_d_i & m_q.memread & d_match_m));

    a_no_load_fwd_m : assert property (@(posedge clk) disable iff (rst)
      !(m_q.memread && (fwd_e_o[2*k +: 2] == FWD_M)));
  end

  assign hazard    = |haz_port;
  assign stall_f_o = hazard;
  assign stall_d_o = hazard;
  assign flush_e_o = hazard & ~ext_stall_i;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (hazard) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (e_bubble && !ext_stall_i) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios plus a randomized program
// compared against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

  localparam int AW = 5;
  localparam int N  = 2;

  typedef struct packed {
    logic            v;
    logic [AW-1:0]   rd;
    logic            rw;
    logic            mr;
    logic [1:0][AW-1:0] rs;
    logic [1:0]      use_m;
    logic            br;
  } ins_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rd_d_i;
  logic            regwrite_d_i, memread_d_i;
  logic [N*AW-1:0] rs_d_i, rs_e_i;
  logic [N-1:0]    rs_use_d_i;
  logic            branch_d_i, flush_e_i, ext_stall_i;
  logic [N*2-1:0]  fwd_e_o;
  logic [N-1:0]    fwd_d_o;
  logic            stall_f_o, stall_d_o, flush_e_o;
`ifdef HAZARD_PERF_EN
  logic [31:0]     stall_cnt_o, bubble_cnt_o;
`endif

  hazard_forward_ctrl #(.REG_AW(AW), .NRS(N)) dut (
    .clk(clk), .rst(rst),
    .rd_d_i(rd_d_i), .regwrite_d_i(regwrite_d_i), .memread_d_i(memread_d_i),
    .rs_d_i(rs_d_i), .rs_use_d_i(rs_use_d_i), .branch_d_i(branch_d_i),
    .rs_e_i(rs_e_i), .flush_e_i(flush_e_i), .ext_stall_i(ext_stall_i),
    .fwd_e_o(fwd_e_o), .fwd_d_o(fwd_d_o),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_e_o(flush_e_o)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: instructions currently in E, M, W (index 0,1,2) and the one presented in D.
  ins_t pipe [3];
  ins_t dcur;
  logic cur_fl, cur_xs, cur_rst;
  logic [N*2-1:0] exp_fe;
  logic [N-1:0]   exp_fd;
  logic           exp_haz;
  logic [31:0]    m_stall_cnt, m_bubble_cnt;
  ins_t NOP;

  function automatic ins_t mk(input int rd, input bit rw, input bit mr,
                              input int s0, input int s1, input bit [1:0] u, input bit br);
    ins_t t;
    logic [31:0] a, b, c;
    a = rd; b = s0; c = s1;
    t = '0;
    t.v = 1'b1; t.rd = a[AW-1:0]; t.rw = rw; t.mr = mr;
    t.rs[0] = b[AW-1:0]; t.rs[1] = c[AW-1:0]; t.use_m = u; t.br = br;
    return t;
  endfunction

  // An instruction "produces" register s if it is real, writes, and s is not x0.
  function automatic bit writes(input logic [AW-1:0] s, input ins_t x);
    return x.v && x.rw && s != 0 && s == x.rd;
  endfunction

  task automatic model_expect();
    exp_haz = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (writes(pipe[0].rs[k], pipe[1]) && !pipe[1].mr) exp_fe[2*k +: 2] = 2'b10;
      else if (writes(pipe[0].rs[k], pipe[2]))           exp_fe[2*k +: 2] = 2'b01;
      else                                               exp_fe[2*k +: 2] = 2'b00;
      exp_fd[k] = writes(dcur.rs[k], pipe[1]) && !pipe[1].mr;
      if (dcur.use_m[k]) begin
        if (pipe[0].mr && writes(dcur.rs[k], pipe[0])) exp_haz = 1'b1;
        if (dcur.br && writes(dcur.rs[k], pipe[0]))    exp_haz = 1'b1;
        if (dcur.br && pipe[1].mr && writes(dcur.rs[k], pipe[1])) exp_haz = 1'b1;
      end
    end
  endtask

  task automatic apply(input ins_t d, input logic f, input logic x, input logic r);
    dcur = d; cur_fl = f; cur_xs = x; cur_rst = r;
    rst = r;
    rd_d_i = d.rd; regwrite_d_i = d.rw; memread_d_i = d.mr;
    rs_d_i = d.rs; rs_use_d_i = d.use_m; branch_d_i = d.br;
    rs_e_i = pipe[0].rs;
    flush_e_i = f; ext_stall_i = x;
    #1;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      m_stall_cnt = 0; m_bubble_cnt = 0;
    end else begin
      if (exp_haz) m_stall_cnt++;
      if (!cur_xs) begin
        if (exp_haz || cur_fl) m_bubble_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (exp_haz || cur_fl) ? '0 : dcur;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    apply(NOP, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    apply(NOP, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    apply(NOP, 1'b0, 1'b0, 1'b0);
    total++;
    if ({fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o} !== '0) begin
      $display("FAIL reset_outputs got=%b want=0", {fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o});
      bad++;
    end
`ifdef HAZARD_PERF_EN
    total++;
    if (stall_cnt_o !== 0 || bubble_cnt_o !== 0) begin
      $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt_o, bubble_cnt_o);
      bad++;
    end
`endif
  endtask

  task automatic test_alu_fwd();
    do_reset();
    apply(mk(5, 1, 0, 1, 2, 3, 0), 0, 0, 0); tick();
    apply(mk(6, 1, 0, 5, 1, 3, 0), 0, 0, 0);
    total++;
    if (stall_d_o !== 1'b0) begin $display("FAIL alu_nostall got=%b want=0", stall_d_o); bad++; end
    tick();
    apply(NOP, 0, 0, 0);
    total++;
    if (fwd_e_o !== 4'b0010) begin $display("FAIL alu_fwd_m got=%b want=0010", fwd_e_o); bad++; end
    tick();
    do_reset();
    apply(mk(5, 1, 0, 1, 2, 3, 0), 0, 0, 0); tick();
    apply(NOP, 0, 0, 0); tick();
    apply(mk(6, 1, 0, 5, 1, 3, 0), 0, 0, 0); tick();
    apply(NOP, 0, 0, 0);
    total++;
    if (fwd_e_o !== 4'b0001) begin $display("FAIL alu_fwd_w got=%b want=0001", fwd_e_o); bad++; end
    tick();
  endtask

  task automatic test_load_use();
    ins_t a;
    a = mk(6, 1, 0, 5, 5, 3, 0);
    do_reset();
    apply(mk(5, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    apply(a, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b111) begin
      $display("FAIL lu_stall got=%b want=111", {stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    apply(a, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o, fwd_d_o} !== 5'b00000) begin
      $display("FAIL lu_release got=%b want=00000", {stall_f_o, stall_d_o, flush_e_o, fwd_d_o}); bad++;
    end
    tick();
    apply(NOP, 0, 0, 0);
    total++;
    if (fwd_e_o !== 4'b0101) begin $display("FAIL lu_fwd_w got=%b want=0101", fwd_e_o); bad++; end
    tick();
  endtask

  task automatic test_branch();
    ins_t beq;
    beq = mk(0, 0, 0, 7, 0, 3, 1);
    do_reset();
    apply(mk(7, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    apply(beq, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b111) begin
      $display("FAIL br_ld_stall1 got=%b want=111", {stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    apply(beq, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o, fwd_d_o} !== 5'b11100) begin
      $display("FAIL br_ld_stall2 got=%b want=11100", {stall_f_o, stall_d_o, flush_e_o, fwd_d_o}); bad++;
    end
    tick();
    apply(beq, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b000) begin
      $display("FAIL br_ld_release got=%b want=000", {stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    do_reset();
    apply(mk(7, 1, 0, 1, 2, 3, 0), 0, 0, 0); tick();
    apply(beq, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b111) begin
      $display("FAIL br_alu_stall got=%b want=111", {stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    apply(beq, 0, 0, 0);
    total++;
    if ({stall_d_o, fwd_d_o} !== 3'b001) begin
      $display("FAIL br_alu_fwd_d got=%b want=001", {stall_d_o, fwd_d_o}); bad++;
    end
    tick();
  endtask

  task automatic test_x0_and_mask();
    do_reset();
    apply(mk(0, 1, 1, 0, 0, 3, 0), 0, 0, 0); tick();
    apply(mk(0, 1, 0, 0, 0, 3, 0), 0, 0, 0); tick();
    apply(mk(0, 1, 0, 0, 0, 3, 0), 0, 0, 0); tick();
    apply(mk(0, 0, 0, 0, 0, 3, 1), 0, 0, 0);
    total++;
    if ({fwd_e_o, fwd_d_o, stall_d_o, flush_e_o} !== '0) begin
      $display("FAIL x0_no_match got=%b want=0", {fwd_e_o, fwd_d_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    do_reset();
    apply(mk(5, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    apply(mk(6, 1, 0, 5, 3, 2'b10, 0), 0, 0, 0);
    total++;
    if (stall_d_o !== 1'b0) begin $display("FAIL use_mask got=%b want=0", stall_d_o); bad++; end
    apply(mk(6, 1, 0, 3, 5, 2'b10, 0), 0, 0, 0);
    total++;
    if (stall_d_o !== 1'b1) begin $display("FAIL use_port1 got=%b want=1", stall_d_o); bad++; end
    tick();
  endtask

  task automatic test_ext_stall();
    ins_t a;
    a = mk(6, 1, 0, 5, 0, 1, 0);
    do_reset();
    apply(mk(5, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(a, 0, 1, 0);
      total++;
      if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b110) begin
        $display("FAIL xs_hold cyc=%0d got=%b want=110", i, {stall_f_o, stall_d_o, flush_e_o}); bad++;
      end
      tick();
    end
    apply(a, 0, 0, 0);
    total++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b111) begin
      $display("FAIL xs_release got=%b want=111", {stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
    apply(a, 0, 0, 0);
    total++;
    if (stall_d_o !== 1'b0) begin $display("FAIL xs_one_bubble got=%b want=0", stall_d_o); bad++; end
    tick();
    apply(NOP, 0, 0, 0);
    total++;
    if (fwd_e_o !== 4'b0001) begin $display("FAIL xs_fwd_w got=%b want=0001", fwd_e_o); bad++; end
    tick();
    // flush and hazard in the same cycle
    do_reset();
    apply(mk(5, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    apply(a, 1, 0, 0);
    total++;
    if ({stall_d_o, flush_e_o} !== 2'b11) begin
      $display("FAIL flush_with_hazard got=%b want=11", {stall_d_o, flush_e_o}); bad++;
    end
    tick();
    // reset in the middle of a load-use stall
    do_reset();
    apply(mk(5, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    apply(a, 0, 0, 1); tick();
    apply(a, 0, 0, 0);
    total++;
    if ({fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o} !== '0) begin
      $display("FAIL rst_mid_stall got=%b want=0", {fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o}); bad++;
    end
    tick();
  endtask

  task automatic test_random();
    ins_t d;
    logic hold;
    logic f, x, r;
    do_reset();
    hold = 1'b0;
    d = NOP;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      x = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 9) == 0);
      if (!hold) begin
        d = mk($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
               $urandom_range(0, 4) == 0);
        if (!d.rw) d.mr = 1'b0;
      end
      apply(d, f, x, r);
      total++;
      if ({fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o} !==
          {exp_fe, exp_fd, exp_haz, exp_haz, exp_haz & ~x}) begin
        $display("FAIL rand cyc=%0d got=%b want=%b", i,
                 {fwd_e_o, fwd_d_o, stall_f_o, stall_d_o, flush_e_o},
                 {exp_fe, exp_fd, exp_haz, exp_haz, exp_haz & ~x});
        bad++;
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (stall_cnt_o !== m_stall_cnt || bubble_cnt_o !== m_bubble_cnt) begin
        $display("FAIL rand_counters cyc=%0d got=%0d/%0d want=%0d/%0d", i,
                 stall_cnt_o, bubble_cnt_o, m_stall_cnt, m_bubble_cnt);
        bad++;
      end
`endif
      hold = (exp_haz || x) && !r;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    NOP = mk(0, 0, 0, 0, 0, 0, 0);
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    m_stall_cnt = 0; m_bubble_cnt = 0;
    exp_haz = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_x0_and_mask();
    test_ext_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
